des_axil_regs: RTL and testbench
================================

# des_axil_regs

AXI4-Lite slave register file that serves as the responder end of the control bus for the DES cracker IP. It accepts single-beat 32-bit writes and reads from the PS/VIP master. It holds the plaintext/ciphertext pair and control bits for the cracking core, and returns core status and the recovered key. It sits between the AXI interconnect and the cracker core, inside the IP top level.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width, covering 8 word registers.
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address; bits [1:0] are ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 each.
- S_AXI_WDATA  in  32.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 each.
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 each.
- S_AXI_ARADDR  in  5.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 each.
- S_AXI_RDATA  out  32.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 each.
- start_o  out  1  one-cycle pulse that starts the search.
- clear_o  out  1  one-cycle pulse that clears the core result.
- plaintext_o  out  64  {PT_HI, PT_LO}.
- ciphertext_o  out  64  {CT_HI, CT_LO}.
- busy_i, done_i, found_i  in  1 each  core status.
- key_i  in  56  recovered key, valid when found_i=1.

## Operation
- Register map (word offset):
  - 0x00 CTRL, RW: bit0 START, bit1 CLEAR, bits [31:2] scratch.
  - 0x04 PT_LO, RW.
  - 0x08 PT_HI, RW.
  - 0x0C CT_LO, RW.
  - 0x10 CT_HI, RW.
  - 0x14 STATUS, RO: {29'b0, found_i, done_i, busy_i}.
  - 0x18 KEY_LO, RO: key_i[31:0].
  - 0x1C KEY_HI, RO: {8'b0, key_i[55:32]}.
- Write path:
  - AW and W are accepted independently, each into its own one-entry holding register.
  - S_AXI_AWREADY = !aw_held and not in reset. S_AXI_WREADY = !w_held and not in reset.
  - When both are held and S_AXI_BVALID=0, the write commits in that cycle: bytes are updated per WSTRB, both holds are released, and S_AXI_BVALID=1 is set on the next edge.
  - BVALID stays high until S_AXI_BREADY=1; further commits stall meanwhile.
  - Write to an RO offset (0x14–0x1C): no state change, BRESP=SLVERR. Every other write returns OKAY.
  - A CTRL commit with WSTRB[0]=1 and WDATA[0]=1 sets start_o=1 for exactly the following cycle. CLEAR works the same way from WDATA[1] to clear_o. The stored CTRL bits keep the written value.
- Read path:
  - S_AXI_ARREADY = !S_AXI_RVALID and not in reset.
  - When ARVALID && ARREADY, RDATA is registered from the selected register and RVALID=1 is set on the next edge. Both hold until RREADY=1.
  - RO values are sampled at the AR handshake cycle.
- A read and a write proceed concurrently. A read of a register that commits in the same cycle returns the pre-write value.

## Timing
- Reset (synchronous, while S_AXI_ARESET=1):
  - All RW registers = 0, holds cleared.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, start_o, clear_o = 0. BRESP, RRESP, RDATA = 0.
  - READY outputs go high on the first edge after reset deasserts.
- Write latency, with AW and W in the same cycle: commit at handshake cycle N; BVALID high at N+1; output ports reflect the new value at N+1; start_o high only in N+1.
- W before AW, or AW before W: commit occurs in the cycle the second channel is handshaken.
- Read latency: AR handshake at N, RVALID and RDATA at N+1.
- Back-to-back throughput: one write per 2 cycles with BREADY tied high; one read per 2 cycles.
- Reset mid-transaction: held AW/W and pending B/R are dropped. No response is issued for them.

## Test plan
- Reset 200 ns, then write 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C and read them back -> each read returns the written value with RRESP=00, every BRESP=00, start_o pulses once after the first write.
- Write 0xAABBCCDD to 0x04 with WSTRB=0101 over a prior value of 0x11223344 -> read 0x04 returns 0x11BB33DD; plaintext_o[31:0] matches it.
- W presented 3 cycles before AW, with BREADY held low for 4 cycles -> exactly one commit, BVALID held stable, no AWREADY/WREADY until B completes.
- Drive key_i=56'hFEDCBA98765432, found_i=1, done_i=1, busy_i=0 -> reads return 0x14=0x6, 0x18=0x98765432, 0x1C=0x00FEDCBA.
- Write 0xFFFFFFFF to 0x18 -> BRESP=10, and a read of 0x18 still returns key_i[31:0].
- Assert reset while RVALID=1 and the W hold is occupied -> next cycle RVALID=0 and all registers are 0. A subsequent write/read to 0x0C behaves normally.

Source files
------------

// File: rtl/des_axil_regs_if.sv
// AXI4-Lite control bus bundle for the DES cracker register file.
interface des_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/des_axil_regs.sv
// AXI4-Lite register file: PT/CT/control for the DES cracker core,
// status and recovered key read back.
module des_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESET,
   des_axil_regs_if.slave         s_axi,
   output logic                   start_o,
   output logic                   clear_o,
   output logic [63:0]            plaintext_o,
   output logic [63:0]            ciphertext_o,
   input  logic                   busy_i,
   input  logic                   done_i,
   input  logic                   found_i,
   input  logic [55:0]            key_i
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int NRW = 5;

   localparam logic [2:0] IDX_CTRL = 3'd0;
   localparam logic [2:0] IDX_STAT = 3'd5;
   localparam logic [2:0] IDX_KLO  = 3'd6;
   localparam logic [2:0] IDX_KHI  = 3'd7;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic          r_rdy;
   logic          r_aw_held;
   logic [2:0]    r_aw_idx;
   logic          r_w_held;
   logic [DW-1:0] r_wdata;
   logic [SW-1:0] r_wstrb;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic          r_start;
   logic          r_clear;
   logic [DW-1:0] r_rw [NRW];

   logic          w_awready;
   logic          w_wready;
   logic          w_arready;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_ar_hs;
   logic          w_commit;
   logic [2:0]    w_wr_idx;
   logic [DW-1:0] w_wr_data;
   logic [SW-1:0] w_wr_strb;
   logic          w_wr_ro;
   logic          w_ctrl_wr;
   logic [2:0]    w_rd_idx;
   logic [DW-1:0] w_rd_mux;
   logic          w_unused;

   function automatic logic [DW-1:0] f_merge(
      input logic [DW-1:0] old,
      input logic [DW-1:0] din,
      input logic [SW-1:0] strb
   );
      logic [DW-1:0] res;
      res = old;
      for (int i = 0; i < SW; i++) begin
         if (strb[i]) res[8*i +: 8] = din[8*i +: 8];
      end
      return res;
   endfunction

   assign w_awready = r_rdy & ~S_AXI_ARESET & ~r_aw_held;
   assign w_wready  = r_rdy & ~S_AXI_ARESET & ~r_w_held;
   assign w_arready = r_rdy & ~S_AXI_ARESET & ~r_rvalid;

   assign w_aw_hs = s_axi.S_AXI_AWVALID & w_awready;
   assign w_w_hs  = s_axi.S_AXI_WVALID & w_wready;
   assign w_ar_hs = s_axi.S_AXI_ARVALID & w_arready;

   // A channel arriving this cycle counts as held, so the commit can
   // happen in the same cycle as the second handshake.
   assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)
                   & ~r_bvalid;

   assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi.S_AXI_AWADDR[4:2];
   assign w_wr_data = r_w_held ? r_wdata : s_axi.S_AXI_WDATA;
   assign w_wr_strb = r_w_held ? r_wstrb : s_axi.S_AXI_WSTRB;
   assign w_wr_ro   = (w_wr_idx >= IDX_STAT);
   assign w_ctrl_wr = w_commit & (w_wr_idx == IDX_CTRL) & w_wr_strb[0];

   assign w_rd_idx = s_axi.S_AXI_ARADDR[4:2];

   always_comb begin
      w_rd_mux = '0;
      unique case (w_rd_idx)
         IDX_STAT: w_rd_mux = {29'b0, found_i, done_i, busy_i};
         IDX_KLO:  w_rd_mux = key_i[31:0];
         IDX_KHI:  w_rd_mux = {8'b0, key_i[55:32]};
         default:  w_rd_mux = r_rw[w_rd_idx];
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_rdy <= 1'b0;
      end else begin
         r_rdy <= 1'b1;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_aw_held <= 1'b0;
         r_aw_idx  <= '0;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
         r_aw_held <= 1'b1;
         r_aw_idx  <= s_axi.S_AXI_AWADDR[4:2];
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_w_held <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else if (w_commit) begin
         r_w_held <= 1'b0;
      end else if (w_w_hs) begin
         r_w_held <= 1'b1;
         r_wdata  <= s_axi.S_AXI_WDATA;
         r_wstrb  <= s_axi.S_AXI_WSTRB;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NRW; i++) r_rw[i] <= '0;
      end else if (w_commit && !w_wr_ro) begin
         r_rw[w_wr_idx] <= f_merge(r_rw[w_wr_idx], w_wr_data, w_wr_strb);
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ro ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
         r_bvalid <= 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_start <= 1'b0;
         r_clear <= 1'b0;
      end else begin
         r_start <= w_ctrl_wr & w_wr_data[0];
         r_clear <= w_ctrl_wr & w_wr_data[1];
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_mux;
      end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign s_axi.S_AXI_AWREADY = w_awready;
   assign s_axi.S_AXI_WREADY  = w_wready;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_BRESP   = r_bresp;
   assign s_axi.S_AXI_ARREADY = w_arready;
   assign s_axi.S_AXI_RVALID  = r_rvalid;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign s_axi.S_AXI_RRESP   = RESP_OKAY;

   assign start_o      = r_start;
   assign clear_o      = r_clear;
   assign plaintext_o  = {r_rw[2], r_rw[1]};
   assign ciphertext_o = {r_rw[4], r_rw[3]};

   assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                       r_rw[0][DW-1:2]} ^ (AW == 0);
endmodule

// File: tb/tb_des_axil_regs.sv
// Directed bench for des_axil_regs: register map, strobes, stalls,
// RO errors and reset mid-transaction.
module tb_des_axil_regs;
   logic        clk;
   logic        rst;
   logic        start_o;
   logic        clear_o;
   logic [63:0] plaintext_o;
   logic [63:0] ciphertext_o;
   logic        busy_i;
   logic        done_i;
   logic        found_i;
   logic [55:0] key_i;

   int checks;
   int errors;
   int start_cnt;
   int clear_cnt;

   des_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

   des_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (bus.slave),
      .start_o      (start_o),
      .clear_o      (clear_o),
      .plaintext_o  (plaintext_o),
      .ciphertext_o (ciphertext_o),
      .busy_i       (busy_i),
      .done_i       (done_i),
      .found_i      (found_i),
      .key_i        (key_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_o === 1'b1) start_cnt++;
      if (clear_o === 1'b1) clear_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic st);
      bit aw_done;
      bit w_done;
      bit a;
      bit w;
      aw_done = 0;
      w_done  = 0;
      resp    = 2'bxx;
      st      = 1'bx;
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_WVALID  = 1'b1;
      for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
         a = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         tick();
         if (a) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
         if (w) begin w_done = 1; bus.S_AXI_WVALID = 1'b0; end
      end
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b1;
      for (int n = 0; n < 20 && bus.S_AXI_BVALID !== 1'b1; n++) tick();
      if (bus.S_AXI_BVALID !== 1'b1) begin
         errors++;
         $display("FAIL write_timeout: addr %h no BVALID", addr);
      end else begin
         resp = bus.S_AXI_BRESP;
         st   = start_o;
      end
      tick();
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
      bit a;
      data = 'x;
      resp = 'x;
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      for (int n = 0; n < 20 && bus.S_AXI_ARVALID; n++) begin
         a = bus.S_AXI_ARREADY;
         tick();
         if (a) bus.S_AXI_ARVALID = 1'b0;
      end
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b1;
      for (int n = 0; n < 20 && bus.S_AXI_RVALID !== 1'b1; n++) tick();
      if (bus.S_AXI_RVALID !== 1'b1) begin
         errors++;
         $display("FAIL read_timeout: addr %h no RVALID", addr);
      end else begin
         data = bus.S_AXI_RDATA;
         resp = bus.S_AXI_RRESP;
      end
      tick();
      bus.S_AXI_RREADY = 1'b0;
   endtask

   logic [1:0]  resp;
   logic [31:0] rd;
   logic        st;

   initial begin
      checks    = 0;
      errors    = 0;
      start_cnt = 0;
      clear_cnt = 0;
      rst = 1'b1;
      busy_i = 1'b0;
      done_i = 1'b0;
      found_i = 1'b0;
      key_i = '0;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWPROT  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARPROT  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;

      repeat (20) @(posedge clk);
      #1;
      chk("rst_awready", bus.S_AXI_AWREADY, 0);
      chk("rst_arready", bus.S_AXI_ARREADY, 0);
      chk("rst_bvalid", bus.S_AXI_BVALID, 0);
      chk("rst_rvalid", bus.S_AXI_RVALID, 0);
      chk("rst_rdata", bus.S_AXI_RDATA, 0);
      chk("rst_start", start_o, 0);
      chk("rst_pt", plaintext_o, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_awready", bus.S_AXI_AWREADY, 1);
      chk("post_rst_wready", bus.S_AXI_WREADY, 1);
      chk("post_rst_arready", bus.S_AXI_ARREADY, 1);

      do_write(5'h00, 32'h1, 4'hF, resp, st);
      chk("wr_ctrl_bresp", resp, 2'b00);
      chk("wr_ctrl_start", st, 1);
      do_write(5'h04, 32'h2, 4'hF, resp, st);
      chk("wr_ptlo_bresp", resp, 2'b00);
      do_write(5'h08, 32'h3, 4'hF, resp, st);
      chk("wr_pthi_bresp", resp, 2'b00);
      do_write(5'h0C, 32'h4, 4'hF, resp, st);
      chk("wr_ctlo_bresp", resp, 2'b00);
      do_read(5'h00, rd, resp);
      chk("rd_ctrl", rd, 32'h1);
      chk("rd_ctrl_rresp", resp, 2'b00);
      do_read(5'h04, rd, resp);
      chk("rd_ptlo", rd, 32'h2);
      do_read(5'h08, rd, resp);
      chk("rd_pthi", rd, 32'h3);
      do_read(5'h0C, rd, resp);
      chk("rd_ctlo", rd, 32'h4);
      chk("rd_ctlo_rresp", resp, 2'b00);
      chk("start_count", start_cnt, 1);
      chk("clear_count", clear_cnt, 0);
      chk("pt_port", plaintext_o, 64'h00000003_00000002);

      do_write(5'h04, 32'h11223344, 4'hF, resp, st);
      do_write(5'h04, 32'hAABBCCDD, 4'b0101, resp, st);
      chk("strb_bresp", resp, 2'b00);
      do_read(5'h04, rd, resp);
      chk("strb_read", rd, 32'h11BB33DD);
      chk("strb_port", plaintext_o[31:0], 32'h11BB33DD);

      do_write(5'h00, 32'h2, 4'hF, resp, st);
      chk("clear_count2", clear_cnt, 1);
      chk("start_count2", start_cnt, 1);

      // Same-cycle write and read of PT_HI: read sees the old value.
      bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h77; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      chk("rw_same_rvalid", bus.S_AXI_RVALID, 1);
      chk("rw_same_rdata", bus.S_AXI_RDATA, 32'h3);
      chk("rw_same_bvalid", bus.S_AXI_BVALID, 1);
      chk("rw_same_port", plaintext_o[63:32], 32'h77);
      bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
      chk("rw_same_rdone", bus.S_AXI_RVALID, 0);
      chk("rw_same_bdone", bus.S_AXI_BVALID, 0);

      // W three cycles ahead of AW, B held off, second write stalls.
      bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_WVALID = 1'b0;
      chk("wfirst_wready", bus.S_AXI_WREADY, 0);
      chk("wfirst_no_commit", ciphertext_o[63:32], 0);
      tick();
      tick();
      chk("wfirst_bvalid_lo", bus.S_AXI_BVALID, 0);
      bus.S_AXI_AWADDR = 5'h10; bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      chk("wfirst_bvalid", bus.S_AXI_BVALID, 1);
      chk("wfirst_commit", ciphertext_o[63:32], 32'hCAFEF00D);
      bus.S_AXI_AWADDR = 5'h10; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      chk("stall_awready", bus.S_AXI_AWREADY, 0);
      chk("stall_wready", bus.S_AXI_WREADY, 0);
      tick();
      tick();
      chk("stall_bvalid", bus.S_AXI_BVALID, 1);
      chk("stall_bresp", bus.S_AXI_BRESP, 2'b00);
      chk("stall_ct", ciphertext_o[63:32], 32'hCAFEF00D);
      bus.S_AXI_BREADY = 1'b1;
      tick();
      chk("stall_bdone", bus.S_AXI_BVALID, 0);
      chk("stall_ct2", ciphertext_o[63:32], 32'hCAFEF00D);
      tick();
      chk("second_bvalid", bus.S_AXI_BVALID, 1);
      chk("second_commit", ciphertext_o[63:32], 32'h12345678);
      tick();
      bus.S_AXI_BREADY = 1'b0;
      chk("second_bdone", bus.S_AXI_BVALID, 0);
      chk("second_awready", bus.S_AXI_AWREADY, 1);

      key_i = 56'hFEDCBA98765432;
      found_i = 1'b1; done_i = 1'b1; busy_i = 1'b0;
      do_read(5'h14, rd, resp);
      chk("rd_status", rd, 32'h6);
      do_read(5'h18, rd, resp);
      chk("rd_key_lo", rd, 32'h98765432);
      do_read(5'h1C, rd, resp);
      chk("rd_key_hi", rd, 32'h00FEDCBA);

      do_write(5'h18, 32'hFFFFFFFF, 4'hF, resp, st);
      chk("ro_bresp", resp, 2'b10);
      do_read(5'h18, rd, resp);
      chk("ro_read", rd, 32'h98765432);
      chk("ro_rresp", resp, 2'b00);

      // Reset with a pending R and a held W.
      bus.S_AXI_ARADDR = 5'h04; bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      chk("mid_rvalid", bus.S_AXI_RVALID, 1);
      chk("mid_wheld", bus.S_AXI_WREADY, 0);
      rst = 1'b1;
      tick();
      chk("mid_rst_rvalid", bus.S_AXI_RVALID, 0);
      chk("mid_rst_rdata", bus.S_AXI_RDATA, 0);
      chk("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
      chk("mid_rst_pt", plaintext_o, 0);
      chk("mid_rst_ct", ciphertext_o, 0);
      chk("mid_rst_awready", bus.S_AXI_AWREADY, 0);
      rst = 1'b0;
      tick();
      chk("mid_post_wready", bus.S_AXI_WREADY, 1);
      chk("mid_post_bvalid", bus.S_AXI_BVALID, 0);
      do_read(5'h00, rd, resp);
      chk("mid_ctrl_zero", rd, 0);
      do_write(5'h0C, 32'h5A5A5A5A, 4'hF, resp, st);
      chk("mid_wr_bresp", resp, 2'b00);
      chk("mid_wr_port", ciphertext_o, 64'h00000000_5A5A5A5A);
      do_read(5'h0C, rd, resp);
      chk("mid_rd", rd, 32'h5A5A5A5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
